// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, the forward S-box table,
// and the enums used by the S-box scheduler.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;

  // Forward AES S-box, entry i = SubBytes(i).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Which requester owns the lanes for the operation in flight.
  typedef enum logic {OWN_ST = 1'b0, OWN_KW = 1'b1} owner_e;

  // Scheduler FSM states.
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// One S-box lane: purely combinational byte substitution from the
// shared package table.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] in_i,
  output logic [BYTE_W-1:0] out_o
);

  assign out_o = sbox_lookup(in_i);

endmodule

// File: rtl/sbox_scheduler.sv
// Time-shares NUM_SBOX S-box lanes between the SubBytes (16-byte state)
// and SubWord (4-byte key word) requesters. One operation at a time,
// round-robin on contention, NUM_SBOX bytes substituted per RUN cycle.
module sbox_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               st_req,
  input  logic [STATE_W-1:0] st_data,
  output logic               st_ack,
  output logic               st_done,
  output logic [STATE_W-1:0] st_result,
  input  logic               kw_req,
  input  logic [WORD_W-1:0]  kw_data,
  output logic               kw_ack,
  output logic               kw_done,
  output logic [WORD_W-1:0]  kw_result,
  output logic               busy
);

  localparam int         ST_CHUNKS = (STATE_W / BYTE_W) / NUM_SBOX;
  localparam int         KW_CHUNKS = (WORD_W / BYTE_W) / NUM_SBOX;
  localparam logic [3:0] ST_LAST   = 4'(ST_CHUNKS - 1);
  localparam logic [3:0] KW_LAST   = 4'(KW_CHUNKS - 1);

  // Lane count must divide both the word and the state evenly.
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("sbox_scheduler: NUM_SBOX must be 1, 2 or 4");
  end

  state_e               state_q, state_d;
  owner_e               own_q, own_d;
  owner_e               last_q, last_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [STATE_W-1:0]   op_q, op_d;
  logic [STATE_W-1:0]   st_res_q, st_res_d;
  logic [WORD_W-1:0]    kw_res_q, kw_res_d;
  logic                 st_ack_q, st_ack_d;
  logic                 kw_ack_q, kw_ack_d;
  logic                 st_done_q, st_done_d;
  logic                 kw_done_q, kw_done_d;
  logic                 busy_q, busy_d;

  logic                 grant_st, grant_kw, last_chunk;

  logic [3:0]           lane_idx [NUM_SBOX];
  logic [BYTE_W-1:0]    lane_in  [NUM_SBOX];
  logic [BYTE_W-1:0]    lane_out [NUM_SBOX];

  // On a tie, the requester that was not served last wins.
  assign grant_st = st_req && (!kw_req || last_q == OWN_KW);
  assign grant_kw = kw_req && (!st_req || last_q == OWN_ST);

  assign last_chunk = (own_q == OWN_ST) ? (cnt_q == ST_LAST) : (cnt_q == KW_LAST);

  // Lane k handles byte cnt*NUM_SBOX + k of the latched operand.
  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
    assign lane_idx[k] = cnt_q * 4'(NUM_SBOX) + 4'(k);
    assign lane_in[k]  = op_q[{lane_idx[k], 3'b000} +: BYTE_W];
    aes_sbox_lut u_lut (
      .in_i  (lane_in[k]),
      .out_o (lane_out[k])
    );
  end

  // State register and all datapath/output registers.
  // NOTE: result registers are reset too, because an aborted operation must leave them cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      own_q     <= OWN_ST;
      last_q    <= OWN_ST;
      cnt_q     <= '0;
      op_q      <= '0;
      st_res_q  <= '0;
      kw_res_q  <= '0;
      st_ack_q  <= 1'b0;
      kw_ack_q  <= 1'b0;
      st_done_q <= 1'b0;
      kw_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      own_q     <= own_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      st_res_q  <= st_res_d;
      kw_res_q  <= kw_res_d;
      st_ack_q  <= st_ack_d;
      kw_ack_q  <= kw_ack_d;
      st_done_q <= st_done_d;
      kw_done_q <= kw_done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: leave IDLE on any grant, leave RUN after the last chunk.
  always_comb begin
    // NOTE: default first so no path leaves the variable unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant_st || grant_kw) state_d = S_RUN;
      S_RUN:  if (last_chunk)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: latch the operand on grant, write lane results while running.
  always_comb begin
    st_ack_d  = 1'b0;
    kw_ack_d  = 1'b0;
    st_done_d = 1'b0;
    kw_done_d = 1'b0;
    own_d     = own_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    st_res_d  = st_res_q;
    kw_res_d  = kw_res_q;
    busy_d    = (state_d == S_RUN);

    unique case (state_q)
      S_IDLE: begin
        if (grant_st) begin
          st_ack_d = 1'b1;
          op_d     = st_data;
          own_d    = OWN_ST;
          cnt_d    = '0;
        end else if (grant_kw) begin
          kw_ack_d = 1'b1;
          op_d     = {{(STATE_W - WORD_W){1'b0}}, kw_data};
          own_d    = OWN_KW;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          if (own_q == OWN_ST) st_res_d[{lane_idx[k], 3'b000} +: BYTE_W] = lane_out[k];
          else                 kw_res_d[{lane_idx[k][1:0], 3'b000} +: BYTE_W] = lane_out[k];
        end
        if (last_chunk) begin
          cnt_d     = '0;
          last_d    = own_q;
          st_done_d = (own_q == OWN_ST);
          kw_done_d = (own_q == OWN_KW);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign st_ack    = st_ack_q;
  assign kw_ack    = kw_ack_q;
  assign st_done   = st_done_q;
  assign kw_done   = kw_done_q;
  assign st_result = st_res_q;
  assign kw_result = kw_res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler. Three instances (NUM_SBOX = 1, 2, 4)
// share the same inputs; cycle-exact checks use the NUM_SBOX = 4 copy,
// latency and table sweeps use all three.
//
// Cycle numbering: cycle 0 is the cycle in which req is presented and the
// grant is decided. Registered outputs from that decision are seen in
// cycle 1, so ack shows in cycle 1, busy in 1..CHUNKS, done in CHUNKS+1.
module tb_sbox_scheduler;
  import aes_pkg::*;

  localparam int NI = 3;

  localparam logic [127:0] ST_VEC = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] ST_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [31:0]  KW_VEC = 32'hcf4f3c09;
  localparam logic [31:0]  KW_EXP = 32'h8a84eb01;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st_req = 1'b0;
  logic         kw_req = 1'b0;
  logic [127:0] st_data = '0;
  logic [31:0]  kw_data = '0;

  logic         st_ack_w  [NI];
  logic         st_done_w [NI];
  logic [127:0] st_res_w  [NI];
  logic         kw_ack_w  [NI];
  logic         kw_done_w [NI];
  logic [31:0]  kw_res_w  [NI];
  logic         busy_w    [NI];

  int n_vec = 0;
  int n_miscmp = 0;

  logic [31:0] tr_st_ack, tr_kw_ack, tr_st_done, tr_kw_done, tr_busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sbox_scheduler #(.NUM_SBOX(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_req    (st_req),
      .st_data   (st_data),
      .st_ack    (st_ack_w[g]),
      .st_done   (st_done_w[g]),
      .st_result (st_res_w[g]),
      .kw_req    (kw_req),
      .kw_data   (kw_data),
      .kw_ack    (kw_ack_w[g]),
      .kw_done   (kw_done_w[g]),
      .kw_result (kw_res_w[g]),
      .busy      (busy_w[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Record the NUM_SBOX=4 instance's pulses for cycles 1..n as bit vectors.
  // Optionally drop a req (and scramble its data) once it has been acked.
  task automatic trace(input int n, input bit drop_st, input bit drop_kw);
    tr_st_ack = '0; tr_kw_ack = '0; tr_st_done = '0; tr_kw_done = '0; tr_busy = '0;
    for (int p = 1; p <= n; p++) begin
      @(negedge clk);
      tr_st_ack[p]  = st_ack_w[2];
      tr_kw_ack[p]  = kw_ack_w[2];
      tr_st_done[p] = st_done_w[2];
      tr_kw_done[p] = kw_done_w[2];
      tr_busy[p]    = busy_w[2];
      if (drop_st && st_ack_w[2]) begin st_req = 1'b0; st_data = ~st_data; end
      if (drop_kw && kw_ack_w[2]) begin kw_req = 1'b0; kw_data = ~kw_data; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; st_req = 1'b0; kw_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation presented to all three instances at once; checks ack
  // cycle, done cycle (CHUNKS+1) and the result for each lane count.
  task automatic shared_op(input string tag, input bit is_st,
                           input logic [127:0] data, input logic [127:0] exp);
    int           ack_p  [NI];
    int           done_p [NI];
    logic [127:0] res    [NI];
    int           chunks;
    for (int i = 0; i < NI; i++) begin ack_p[i] = -1; done_p[i] = -1; res[i] = '0; end
    if (is_st) begin st_req = 1'b1; st_data = data; end
    else       begin kw_req = 1'b1; kw_data = data[31:0]; end
    for (int p = 1; p <= 20; p++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if ((is_st ? st_ack_w[i] : kw_ack_w[i]) && ack_p[i] < 0) ack_p[i] = p;
        if ((is_st ? st_done_w[i] : kw_done_w[i]) && done_p[i] < 0) begin
          done_p[i] = p;
          res[i]    = is_st ? st_res_w[i] : {96'b0, kw_res_w[i]};
        end
      end
      if (ack_p[0] >= 0 || ack_p[1] >= 0 || ack_p[2] >= 0) begin st_req = 1'b0; kw_req = 1'b0; end
    end
    for (int i = 0; i < NI; i++) begin
      chunks = (is_st ? 16 : 4) / (1 << i);
      check($sformatf("%s ack_cycle n%0d", tag, 1 << i), 128'(ack_p[i]), 128'(1));
      check($sformatf("%s done_cycle n%0d", tag, 1 << i), 128'(done_p[i]), 128'(chunks + 1));
      check($sformatf("%s result n%0d", tag, 1 << i), res[i], exp);
    end
  endtask

  initial begin
    logic        any_done;
    logic [31:0] word, wexp;

    // Reset held with both requests high: everything quiet, no ack.
    rst_n = 1'b0; st_req = 1'b1; kw_req = 1'b1; st_data = ST_VEC; kw_data = KW_VEC;
    repeat (3) @(negedge clk);
    check("rst st_ack",    st_ack_w[2],  0);
    check("rst kw_ack",    kw_ack_w[2],  0);
    check("rst st_done",   st_done_w[2], 0);
    check("rst kw_done",   kw_done_w[2], 0);
    check("rst busy",      busy_w[2],    0);
    check("rst st_result", st_res_w[2],  0);
    check("rst kw_result", kw_res_w[2],  0);

    // Release with both still high: kw first, then alternation.
    // kw: grant 0, done 2; st: grant 2, done 7; kw: grant 7, done 9; st: grant 9, done 14.
    rst_n = 1'b1;
    trace(14, 1'b0, 1'b0);
    st_req = 1'b0; kw_req = 1'b0;
    check("arb kw_ack",    tr_kw_ack,  32'h0000_0102);
    check("arb kw_done",   tr_kw_done, 32'h0000_0204);
    check("arb st_ack",    tr_st_ack,  32'h0000_0408);
    check("arb st_done",   tr_st_done, 32'h0000_4080);
    check("arb busy",      tr_busy,    32'h0000_3d7a);
    check("arb st_result", st_res_w[2], ST_EXP);
    check("arb kw_result", kw_res_w[2], {96'b0, KW_EXP});

    // ST only; data scrambled after ack must not matter.
    do_reset();
    st_req = 1'b1; st_data = ST_VEC;
    trace(8, 1'b1, 1'b0);
    check("st st_ack",    tr_st_ack,  32'h0000_0002);
    check("st busy",      tr_busy,    32'h0000_001e);
    check("st st_done",   tr_st_done, 32'h0000_0020);
    check("st kw_ack",    tr_kw_ack,  0);
    check("st st_result", st_res_w[2], ST_EXP);
    check("st kw_result", kw_res_w[2], 0);

    // KW only; st_result must be left alone.
    kw_req = 1'b1; kw_data = KW_VEC;
    trace(4, 1'b0, 1'b1);
    check("kw kw_ack",    tr_kw_ack,  32'h0000_0002);
    check("kw busy",      tr_busy,    32'h0000_0002);
    check("kw kw_done",   tr_kw_done, 32'h0000_0004);
    check("kw st_done",   tr_st_done, 0);
    check("kw kw_result", kw_res_w[2], {96'b0, KW_EXP});
    check("kw st_result", st_res_w[2], ST_EXP);

    // Reset in cycle 3 of an ST op: no done, results cleared, idle.
    do_reset();
    st_req = 1'b1; st_data = ST_VEC;
    trace(3, 1'b1, 1'b0);
    check("abort busy_before", tr_busy, 32'h0000_000e);
    rst_n = 1'b0;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_done = any_done | st_done_w[2];
    end
    check("abort st_done",   any_done,    0);
    check("abort st_result", st_res_w[2], 0);
    check("abort busy",      busy_w[2],   0);
    rst_n = 1'b1; st_req = 1'b1; st_data = ST_VEC;
    trace(8, 1'b1, 1'b0);
    check("rerun st_done",   tr_st_done,  32'h0000_0020);
    check("rerun st_result", st_res_w[2], ST_EXP);

    // Latency and table sweep across lane counts 1, 2, 4.
    do_reset();
    shared_op("st", 1'b1, ST_VEC, ST_EXP);
    shared_op("kw_fips", 1'b0, {96'b0, KW_VEC}, {96'b0, KW_EXP});
    // 00->63, 00->63, 53->ed, ff->16
    shared_op("kw_spot", 1'b0, {96'b0, 32'hff53_0000}, {96'b0, 32'h16ed_6363});
    for (int j = 0; j < 64; j++) begin
      word = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
      for (int b = 0; b < 4; b++) wexp[8 * b +: 8] = sbox_lookup(word[8 * b +: 8]);
      shared_op($sformatf("sweep%0d", j), 1'b0, {96'b0, word}, {96'b0, wexp});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sbox_scheduler.md
Name: sbox_scheduler

Overview:
- Shares a small pool of AES S-box lookup lanes between two requesters: the cipher-state SubBytes path (16 bytes) and the key-expansion SubWord path (4 bytes).
- Accepts one operation at a time through a req/ack handshake, round-robin arbitrated.
- Feeds NUM_SBOX bytes per cycle through the lanes and returns a registered result with a one-cycle done pulse.
- Sits between the round controller / key-expansion logic and the S-box lookup lanes.

Parameters:
- NUM_SBOX, 4, number of S-box lanes used per cycle; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_req  in  1  state SubBytes request (level)
- st_data  in  128  state bytes; byte i = st_data[8i+7:8i]
- st_ack  out  1  one-cycle pulse: st_data latched
- st_done  out  1  one-cycle pulse: st_result valid
- st_result  out  128  SubBytes(st_data), byte-for-byte
- kw_req  in  1  SubWord request (level)
- kw_data  in  32  word bytes; byte i = kw_data[8i+7:8i]
- kw_ack  out  1  one-cycle pulse: kw_data latched
- kw_done  out  1  one-cycle pulse: kw_result valid
- kw_result  out  32  SubWord(kw_data)
- busy  out  1  high while FSM not IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: all outputs 0; FSM = IDLE; last-served = ST, so kw wins the first tie after reset.
- FSM states:
  - IDLE:
    - If exactly one req is high, grant it.
    - If both are high, grant the one not last served.
    - On grant: ack pulse asserted in the grant cycle (cycle 0); data latched into the operand register; owner recorded; chunk counter = 0; go to RUN.
  - RUN:
    - Each cycle, lane k looks up operand byte (cnt*NUM_SBOX + k).
    - Each output byte is written into the owner's result register at the same byte position.
    - cnt increments each RUN cycle.
    - On the last chunk (cnt = CHUNKS-1): set the owner's done for the next cycle, update last-served, return to IDLE.
- Chunk count: CHUNKS = 16/NUM_SBOX for ST, 4/NUM_SBOX for KW. Counter width is 4 bits; it never wraps past CHUNKS-1.
- Timing:
  - Latency: ack at cycle 0, RUN at cycles 1..CHUNKS, done at cycle CHUNKS+1.
  - IDLE may grant a new request in the same cycle done is high (back-to-back throughput: one op per CHUNKS+1 cycles).
- Result registers:
  - Each channel has its own result register. Partial writes are not visible as valid until done.
  - The register holds its value until that channel's next operation overwrites it. The other channel's operation never disturbs it.
- Request rules:
  - req deasserted before ack withdraws the request.
  - req changes after ack have no effect.
  - data only needs to be stable in the ack cycle.
  - req held high after done starts a new operation under arbitration.
- Reset mid-operation: immediate abort; no done pulse; results cleared to 0; FSM returns to IDLE.
- busy = 1 in RUN only.

Decomposition:
- Shared package aes_pkg holds:
  - AES byte/word/state width constants (8/32/128).
  - The 256-entry S-box constant table.
  - The owner enum {OWN_ST, OWN_KW}.
  - The FSM state enum {S_IDLE, S_RUN}.
- One sub-module is natural: aes_sbox_lut, a combinational 8-bit to 8-bit lookup from the package table, instantiated NUM_SBOX times.

Test Plan:
1. Reset: hold rst_n=0 with both reqs high → all outputs 0, no ack. Release → kw_ack at the first edge.
2. KW only, NUM_SBOX=4: kw_data=32'hcf4f3c09 → kw_ack cycle 0, busy cycle 1, kw_done cycle 2, kw_result=32'h8a84eb01; st_result unchanged.
3. ST only, NUM_SBOX=4: st_data=128'h193de3bea0f4e22b9ac68d2ae9f84808 → st_done cycle 5, st_result=128'hd42711aee0bf98f1b8b45de51e415230.
4. Contention after reset, both reqs high at cycle 0 → kw_ack 0, kw_done 2, st_ack 2, st_done 7. Both still high → kw_ack 7 (round-robin alternates).
5. Reset mid-op: start the ST op of test 3, pull rst_n low at cycle 3 → no st_done, st_result=0, busy=0. Rerun after reset → correct result at cycle 5.
6. NUM_SBOX=1 and 2:
   - ST latency 17 and 9 cycles respectively.
   - Sweep all 256 byte values via 64 KW words (e.g. 00→63, 53→ed, ff→16).
   - Compare every result against the golden package table.
